// File: rtl/ram_loader.sv
// ram_loader: accepts a framed byte stream (count, payload, checksum) and writes the payload into the SAP-1 RAM from address 0.
// Optional macro LOADER_VERIFY_EN adds a read-back checksum sweep (VERIFY state) before DONE.
module ram_loader #(
  parameter int RAM_DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  mclk,
  input  logic                  i_rst_n,
  input  logic                  mclk_en,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [WIDTH-1:0]      i_byte_data,
  output logic                  o_byte_ready,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_load_enable,
  output logic [WIDTH-1:0]      o_load_data,
  input  logic [WIDTH-1:0]      i_ram_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR, S_VERIFY
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [WIDTH-1:0]      sum;
  logic [WIDTH-1:0]      frame_sum;

  // A count of zero means a full RAM image.
  function automatic logic [ADDR_WIDTH-1:0] last_index(input logic [WIDTH-1:0] n);
    if (n == '0) return ADDR_WIDTH'(RAM_DEPTH - 1);
    return ADDR_WIDTH'(n - WIDTH'(1));
  endfunction

  function automatic logic count_too_big(input logic [WIDTH-1:0] n);
    return {1'b0, n} > (WIDTH+1)'(RAM_DEPTH);
  endfunction

  assign frame_sum    = sum + i_byte_data;
  assign o_byte_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
  assign o_busy       = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

`ifdef LOADER_VERIFY_EN
  logic [WIDTH-1:0] vsum;
  logic [WIDTH-1:0] chk;
  logic [WIDTH-1:0] vsum_next;
  logic [WIDTH-1:0] vfinal;
  assign vsum_next = vsum + i_ram_data;
  assign vfinal    = vsum_next + chk;
`else
  logic unused_ram_data;
  assign unused_ram_data = ^i_ram_data;
`endif

  always_ff @(posedge mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      last_addr     <= '0;
      sum           <= '0;
      o_address     <= '0;
      o_load_enable <= 1'b0;
      o_load_data   <= '0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
`ifdef LOADER_VERIFY_EN
      vsum          <= '0;
      chk           <= '0;
`endif
    end else if (mclk_en) begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            state     <= S_COUNT;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_address <= '0;
            sum       <= '0;
          end
        end
        S_COUNT: begin
          if (i_byte_valid) begin
            if (count_too_big(i_byte_data)) begin
              state   <= S_ERROR;
              o_error <= 1'b1;
            end else begin
              last_addr <= last_index(i_byte_data);
              state     <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (i_byte_valid) begin
            o_load_data   <= i_byte_data;
            o_load_enable <= 1'b1;
            sum           <= frame_sum;
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          // The RAM commits on this edge; the strobe drops with it.
          o_load_enable <= 1'b0;
          if (o_address == last_addr) begin
            state <= S_CHECK;
          end else begin
            o_address <= o_address + ADDR_WIDTH'(1);
            state     <= S_DATA;
          end
        end
        S_CHECK: begin
          if (i_byte_valid) begin
            if (frame_sum == '0) begin
`ifdef LOADER_VERIFY_EN
              state     <= S_VERIFY;
              o_address <= '0;
              vsum      <= '0;
              chk       <= i_byte_data;
`else
              state  <= S_DONE;
              o_done <= 1'b1;
`endif
            end else begin
              state   <= S_ERROR;
              o_error <= 1'b1;
            end
          end
        end
`ifdef LOADER_VERIFY_EN
        S_VERIFY: begin
          if (o_address == last_addr) begin
            if (vfinal == '0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state   <= S_ERROR;
              o_error <= 1'b1;
            end
          end else begin
            vsum      <= vsum_next;
            o_address <= o_address + ADDR_WIDTH'(1);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: random framed streams against a frame-level model of RAM contents and flags.
module tb_ram_loader;
  typedef logic [7:0] bq_t[$];

  logic       mclk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       mclk_en = 1'b0;
  logic       i_start = 1'b0;
  logic       i_byte_valid = 1'b0;
  logic [7:0] i_byte_data = 8'h00;
  logic       o_byte_ready;
  logic [3:0] o_address;
  logic       o_load_enable;
  logic [7:0] o_load_data;
  logic [7:0] i_ram_data;
  logic       o_busy, o_done, o_error;

  logic [7:0] ram [16];
  logic [7:0] exp_ram [16];
  int         corrupt_addr = -1;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [3:0] ver_addr_q[$];
  int         strobe_viol = 0;
  logic       prev_le = 1'b0;

  ram_loader #(.RAM_DEPTH(16), .WIDTH(8)) dut (
    .mclk(mclk), .i_rst_n(i_rst_n), .mclk_en(mclk_en), .i_start(i_start),
    .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data), .o_byte_ready(o_byte_ready),
    .o_address(o_address), .o_load_enable(o_load_enable), .o_load_data(o_load_data),
    .i_ram_data(i_ram_data), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 mclk = ~mclk;

  assign i_ram_data = ram[o_address] ^ ((int'(o_address) == corrupt_addr) ? 8'h40 : 8'h00);

  // Behaves as the RAM: commits on an enabled edge with the strobe high.
  always @(posedge mclk) begin
    if (!i_rst_n) begin
      prev_le = 1'b0;
    end else if (mclk_en) begin
      if (o_load_enable) begin
        ram[o_address] = o_load_data;
        wr_addr_q.push_back(o_address);
        wr_data_q.push_back(o_load_data);
      end
      if (o_load_enable && prev_le) strobe_viol++;
      if (o_busy && !o_byte_ready && !o_load_enable) ver_addr_q.push_back(o_address);
      prev_le = o_load_enable;
    end
  end

  task automatic prep_ram();
    for (int i = 0; i < 16; i++) begin
      ram[i] = 8'hC0 | 8'(i);
      exp_ram[i] = ram[i];
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    ver_addr_q.delete();
    strobe_viol = 0;
  endtask

  // Frame-level reference: count, payload, checksum -> RAM image, flags, write count.
  task automatic model(input bq_t fr, output bit ed, output bit ee, output int nw);
    int n;
    logic [7:0] s;
    n = (fr[0] == 8'h00) ? 16 : int'(fr[0]);
    if (n > 16) begin
      ed = 0; ee = 1; nw = 0;
      return;
    end
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_ram[i] = fr[1+i];
      s = s + fr[1+i];
    end
    s = s + fr[n+1];
    ed = (s == 8'h00);
    ee = !ed;
    nw = n;
  endtask

  task automatic run_frame(input bq_t fr, input bit thr, input bit gaps, input bit pulse,
                           output bit tmo);
    int k = 0;
    int budget = 0;
    int cyc = 0;
    bit acc, pulsed = 0;
    tmo = 0;
    @(negedge mclk); mclk_en = 1'b1; i_start = 1'b1;
    @(negedge mclk); i_start = 1'b0;
    while (k < fr.size() && budget < 3000) begin
      mclk_en = thr ? (cyc % 3 == 0) : 1'b1;
      i_byte_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_byte_data = fr[k];
      if (pulse && !pulsed && k == 2 && mclk_en) begin
        i_start = 1'b1; pulsed = 1;
      end else begin
        i_start = 1'b0;
      end
      #1 acc = mclk_en && i_byte_valid && o_byte_ready;
      @(negedge mclk);
      if (acc) k++;
      cyc++; budget++;
    end
    i_byte_valid = 1'b0;
    i_start = 1'b0;
    if (budget >= 3000) tmo = 1;
    budget = 0;
    while (o_busy && budget < 400) begin
      mclk_en = thr ? (cyc % 3 == 0) : 1'b1;
      @(negedge mclk);
      cyc++; budget++;
    end
    if (budget >= 400) tmo = 1;
    mclk_en = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge mclk);
    n_checks++; if (o_address !== 4'h0) begin n_fail++; $display("FAIL reset_address got %h want 0", o_address); end
    n_checks++; if (o_load_enable !== 1'b0) begin n_fail++; $display("FAIL reset_load_enable got %b want 0", o_load_enable); end
    n_checks++; if (o_load_data !== 8'h00) begin n_fail++; $display("FAIL reset_load_data got %h want 00", o_load_data); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_checks++; if (o_done !== 1'b0 || o_error !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", o_done, o_error); end
    n_checks++; if (o_byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", o_byte_ready); end
    i_rst_n = 1'b1;
    @(negedge mclk);
  endtask

  task automatic test_good_frame();
    bq_t fr = '{8'h03, 8'h1E, 8'h2F, 8'h00, 8'hB3};
    bit ed, ee, tmo; int nw;
    prep_ram();
    model(fr, ed, ee, nw);
    run_frame(fr, 0, 0, 0, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL good_timeout got 1 want 0"); end
    n_checks++; if (o_done !== ed || o_error !== ee) begin n_fail++; $display("FAIL good_flags got %b%b want %b%b", o_done, o_error, ed, ee); end
    n_checks++; if (wr_addr_q.size() != nw) begin n_fail++; $display("FAIL good_nwrites got %0d want %0d", wr_addr_q.size(), nw); end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      n_checks++; if (wr_addr_q[i] !== 4'(i)) begin n_fail++; $display("FAIL good_wr_addr[%0d] got %h want %h", i, wr_addr_q[i], 4'(i)); end
    end
    n_checks++; if (strobe_viol != 0) begin n_fail++; $display("FAIL good_strobe_width got %0d want 0", strobe_viol); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (ram[i] !== exp_ram[i]) begin n_fail++; $display("FAIL good_ram[%0d] got %h want %h", i, ram[i], exp_ram[i]); end
    end
  endtask

  task automatic test_bad_checksum();
    bq_t fr = '{8'h03, 8'h1E, 8'h2F, 8'h00, 8'hB4};
    bit ed, ee, tmo; int nw;
    prep_ram();
    model(fr, ed, ee, nw);
    run_frame(fr, 0, 0, 0, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL badsum_timeout got 1 want 0"); end
    n_checks++; if (o_done !== 1'b0 || o_error !== 1'b1) begin n_fail++; $display("FAIL badsum_flags got %b%b want 01", o_done, o_error); end
    n_checks++; if (wr_addr_q.size() != nw) begin n_fail++; $display("FAIL badsum_nwrites got %0d want %0d", wr_addr_q.size(), nw); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (ram[i] !== exp_ram[i]) begin n_fail++; $display("FAIL badsum_ram[%0d] got %h want %h", i, ram[i], exp_ram[i]); end
    end
  endtask

  task automatic test_full_and_oversize();
    bq_t fr;
    bit ed, ee, tmo; int nw;
    prep_ram();
    fr.push_back(8'h00);
    for (int i = 0; i < 16; i++) fr.push_back(8'(i));
    fr.push_back(8'h88);
    model(fr, ed, ee, nw);
    run_frame(fr, 0, 0, 0, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL full_timeout got 1 want 0"); end
    n_checks++; if (o_done !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL full_flags got %b%b want 10", o_done, o_error); end
    n_checks++; if (wr_addr_q.size() != 16) begin n_fail++; $display("FAIL full_nwrites got %0d want 16", wr_addr_q.size()); end
    n_checks++; if (o_address !== 4'hF) begin n_fail++; $display("FAIL full_addr_nowrap got %h want f", o_address); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (ram[i] !== exp_ram[i]) begin n_fail++; $display("FAIL full_ram[%0d] got %h want %h", i, ram[i], exp_ram[i]); end
    end
    prep_ram();
    fr = '{8'h11};
    model(fr, ed, ee, nw);
    run_frame(fr, 0, 0, 0, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL over_timeout got 1 want 0"); end
    n_checks++; if (o_done !== ed || o_error !== ee) begin n_fail++; $display("FAIL over_flags got %b%b want %b%b", o_done, o_error, ed, ee); end
    n_checks++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL over_nwrites got %0d want 0", wr_addr_q.size()); end
  endtask

  task automatic test_throttled();
    bq_t fr = '{8'h03, 8'h1E, 8'h2F, 8'h00, 8'hB3};
    bit ed, ee, tmo; int nw;
    prep_ram();
    model(fr, ed, ee, nw);
    run_frame(fr, 1, 1, 1, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL thr_timeout got 1 want 0"); end
    n_checks++; if (o_done !== ed || o_error !== ee) begin n_fail++; $display("FAIL thr_flags got %b%b want %b%b", o_done, o_error, ed, ee); end
    n_checks++; if (wr_addr_q.size() != nw) begin n_fail++; $display("FAIL thr_nwrites got %0d want %0d", wr_addr_q.size(), nw); end
    n_checks++; if (strobe_viol != 0) begin n_fail++; $display("FAIL thr_strobe_width got %0d want 0", strobe_viol); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (ram[i] !== exp_ram[i]) begin n_fail++; $display("FAIL thr_ram[%0d] got %h want %h", i, ram[i], exp_ram[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      bq_t fr;
      bit ed, ee, tmo; int nw, n;
      logic [7:0] s = 8'h00;
      prep_ram();
      n = $urandom_range(1, 16);
      fr.push_back((n == 16 && $urandom_range(0, 1) == 1) ? 8'h00 : 8'(n));
      for (int i = 0; i < n; i++) begin
        fr.push_back(8'($urandom));
        s = s + fr[i+1];
      end
      fr.push_back(($urandom_range(0, 1) == 1) ? (8'h00 - s) : (8'h00 - s + 8'($urandom_range(1, 255))));
      model(fr, ed, ee, nw);
      run_frame(fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tmo);
      n_checks++; if (tmo) begin n_fail++; $display("FAIL rnd%0d_timeout got 1 want 0", it); end
      n_checks++; if (o_done !== ed || o_error !== ee) begin n_fail++; $display("FAIL rnd%0d_flags got %b%b want %b%b", it, o_done, o_error, ed, ee); end
      n_checks++; if (wr_addr_q.size() != nw) begin n_fail++; $display("FAIL rnd%0d_nwrites got %0d want %0d", it, wr_addr_q.size(), nw); end
      for (int i = 0; i < 16; i++) begin
        n_checks++; if (ram[i] !== exp_ram[i]) begin n_fail++; $display("FAIL rnd%0d_ram[%0d] got %h want %h", it, i, ram[i], exp_ram[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t fr = '{8'h03, 8'h1E, 8'h2F, 8'h00, 8'hB3};
    int k = 0;
    int budget = 0;
    bit acc;
    prep_ram();
    @(negedge mclk); mclk_en = 1'b1; i_start = 1'b1;
    @(negedge mclk); i_start = 1'b0;
    while (wr_addr_q.size() < 2 && budget < 200) begin
      i_byte_valid = 1'b1;
      i_byte_data = fr[k];
      #1 acc = o_byte_ready;
      @(negedge mclk);
      if (acc) k++;
      budget++;
    end
    i_byte_valid = 1'b0;
    n_checks++; if (budget >= 200) begin n_fail++; $display("FAIL rstmid_timeout got 1 want 0"); end
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_busy !== 1'b0 || o_byte_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got busy=%b ready=%b want 0 0", o_busy, o_byte_ready); end
    n_checks++; if (o_address !== 4'h0 || o_load_enable !== 1'b0 || o_load_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_outs got %h %b %h want 0 0 00", o_address, o_load_enable, o_load_data); end
    n_checks++; if (o_done !== 1'b0 || o_error !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got %b%b want 00", o_done, o_error); end
    n_checks++; if (ram[0] !== 8'h1E || ram[1] !== 8'h2F) begin n_fail++; $display("FAIL rstmid_ram got %h %h want 1e 2f", ram[0], ram[1]); end
    n_checks++; if (ram[2] !== 8'hC2) begin n_fail++; $display("FAIL rstmid_ram2 got %h want c2", ram[2]); end
    @(negedge mclk);
    i_rst_n = 1'b1;
    @(negedge mclk);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_stays_idle got %b want 0", o_busy); end
  endtask

`ifdef LOADER_VERIFY_EN
  task automatic test_verify();
    bq_t fr = '{8'h03, 8'h1E, 8'h2F, 8'h00, 8'hB3};
    bit tmo;
    prep_ram();
    run_frame(fr, 0, 0, 0, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL ver_timeout got 1 want 0"); end
    n_checks++; if (o_done !== 1'b1 || o_error !== 1'b0) begin n_fail++; $display("FAIL ver_flags got %b%b want 10", o_done, o_error); end
    n_checks++; if (ver_addr_q.size() != 3) begin n_fail++; $display("FAIL ver_sweep_len got %0d want 3", ver_addr_q.size()); end
    for (int i = 0; i < ver_addr_q.size(); i++) begin
      n_checks++; if (ver_addr_q[i] !== 4'(i)) begin n_fail++; $display("FAIL ver_sweep[%0d] got %h want %h", i, ver_addr_q[i], 4'(i)); end
    end
    prep_ram();
    corrupt_addr = 1;
    run_frame(fr, 0, 0, 0, tmo);
    corrupt_addr = -1;
    n_checks++; if (tmo) begin n_fail++; $display("FAIL vercorrupt_timeout got 1 want 0"); end
    n_checks++; if (o_done !== 1'b0 || o_error !== 1'b1) begin n_fail++; $display("FAIL vercorrupt_flags got %b%b want 01", o_done, o_error); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_full_and_oversize();
    test_throttled();
    test_random();
    test_reset_mid();
`ifdef LOADER_VERIFY_EN
    test_verify();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Program-loading initiator for the SAP-1 16x8 RAM: takes a framed byte stream (length, payload, checksum) over a valid/ready handshake and drives the RAM's address, load-enable and load-data inputs.
- Writes consecutive words from address 0.
- Holds the CPU off the RAM while loading and reports done/error.
- Sits between the host/serial front end and the RAM address mux in the top level.

Parameters:
- RAM_DEPTH, 16, words in the target RAM; ADDR_WIDTH = $clog2(RAM_DEPTH); RAM_DEPTH <= 2**WIDTH.
- WIDTH, 8, word and stream byte width.

Ports:
- mclk  input  1  system clock; all state on posedge.
- i_rst_n  input  1  asynchronous active-low reset.
- mclk_en  input  1  clock enable; state advances only when 1.
- i_start  input  1  begin a load frame; honoured in IDLE, DONE or ERROR.
- i_byte_valid  input  1  stream byte present.
- i_byte_data  input  WIDTH  stream byte.
- o_byte_ready  output  1  loader can accept a byte this cycle.
- o_address  output  ADDR_WIDTH  RAM address, registered.
- o_load_enable  output  1  RAM write strobe, registered.
- o_load_data  output  WIDTH  RAM write data, registered.
- i_ram_data  input  WIDTH  RAM combinational read data; used only with LOADER_VERIFY_EN.
- o_busy  output  1  high in any state except IDLE/DONE/ERROR; CPU must be held.
- o_done  output  1  sticky success flag.
- o_error  output  1  sticky failure flag.

Behaviour:
- Reset (async, i_rst_n=0):
  - State = IDLE.
  - All outputs 0; internal count, address and sum also 0.
- Byte acceptance: "accept" = mclk_en & i_byte_valid & o_byte_ready. o_byte_ready is combinational from state: 1 only in COUNT, DATA and CHECK.
- IDLE/DONE/ERROR:
  - i_start & mclk_en -> COUNT.
  - On that transition, clear o_done, o_error, the address counter and the sum.
  - i_start in any other state is ignored.
- COUNT: on accept, N = byte.
  - If N == 0, treat as N = RAM_DEPTH.
  - If N > RAM_DEPTH -> ERROR.
  - Otherwise -> DATA.
- DATA: on accept:
  - o_load_data <= byte; o_load_enable <= 1; sum <= sum + byte (mod 2**WIDTH).
  - -> WRITE.
- WRITE:
  - o_load_enable is high for exactly one mclk_en-qualified cycle, so the RAM commits at that edge.
  - At that edge: o_load_enable <= 0.
  - If address == N-1 -> CHECK, and address holds.
  - Else address <= address+1 -> DATA.
- Write-data latency: a byte accepted at edge k is written to RAM at the next enabled edge. Peak rate is one word per 2 enabled cycles.
- CHECK: on accept:
  - If (sum + byte) mod 2**WIDTH == 0 -> DONE (or VERIFY with the option); o_done <= 1.
  - Else -> ERROR; o_error <= 1.
- Outputs are held when mclk_en=0; no state changes and no strobe.
- o_load_enable is never high outside WRITE.
- o_address always stays below RAM_DEPTH; it wraps to 0 only when the next frame starts.
- Reset mid-frame: abort immediately to IDLE. Words already written stay in RAM; no flags are set.
- i_byte_valid while not ready: the byte is not consumed; the source must hold it.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- Defined: CHECK success -> VERIFY instead of DONE.
  - Address resets to 0; vsum is cleared.
  - Each enabled cycle: vsum += i_ram_data; address++.
  - After N words, vsum + received checksum == 0 -> DONE with o_done=1; else ERROR with o_error=1.
  - o_busy stays high during VERIFY; o_load_enable stays 0.
- Undefined:
  - No VERIFY state; i_ram_data is unused.
  - CHECK success -> DONE directly.

Test Plan:
- Reset mid-DATA after 2 words -> all outputs 0, state IDLE, o_done=o_error=0; RAM[0..1] keep the written values.
- i_start, stream 03,1E,2F,00,B3 -> RAM[0]=1E, RAM[1]=2F, RAM[2]=00, o_done=1, o_error=0. Each write is a single-cycle strobe at addresses 0,1,2.
- Same frame with checksum B4 -> o_error=1, o_done=0; RAM[0..2] still written.
- Count byte 00 followed by 16 bytes 00..0F and checksum 88 -> all 16 addresses written, no address wrap, o_done=1. Count byte 11 -> o_error=1 immediately, no write strobes.
- mclk_en toggling 1-of-3 cycles and i_byte_valid gaps, plus an i_start pulse mid-frame -> identical RAM contents and flags to the free-running case, and the i_start pulse is ignored.
- With LOADER_VERIFY_EN defined:
  - Stream 03,1E,2F,00,B3 -> a VERIFY sweep over addresses 0..2, then o_done=1.
  - Forcing i_ram_data corrupted at address 1 -> o_error=1.
